// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and transmitter state encoding
// for the memory-mapped UART transmitter.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU word-bus slave port shared with the block RAM: word address, byte-masked
// write, registered read data.
interface uart_tx_mmio_if;
  logic        sel;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_r;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;

  modport master (
    output sel, bus_addr, bus_data_w, bus_mask_w,
    input  bus_data_r
  );

  modport slave (
    input  sel, bus_addr, bus_data_w, bus_mask_w,
    output bus_data_r
  );
endinterface

// File: rtl/uart_fifo.sv
// Byte-wide synchronous first-word-fall-through FIFO; a push while full is
// accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests against occupancy
  always_comb begin
    do_pop_s  = pop && (count_r != '0);
    do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
  end

  // Storage array, written on accepted pushes only
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR registers on the
// CPU word bus, a byte FIFO and a baud-timed serialiser driving tx.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int DIV_RESET  = 16
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_mmio_if.slave bus,
  output logic          tx,
  output logic          irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // A zero divisor would stall the baud counter, so it behaves as one.
  function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] d);
    return (d == '0) ? DIV_WIDTH'(1) : d;
  endfunction

  logic [DIV_WIDTH-1:0] div_r;
  logic                 ovf_r;
  logic [31:0]          rdata_r;
  tx_state_t            state_r, state_s;
  logic [DIV_WIDTH-1:0] cnt_r, cnt_s;
  logic [2:0]           bit_r, bit_s;
  logic [7:0]           sh_r, sh_s;
  logic                 tx_r, tx_s;

  logic                 wr_en_s, rd_en_s, txdata_wr_s;
  logic                 ovf_set_s, ovf_clr_s;
  logic [1:0]           reg_off_s;
  logic [31:0]          rd_mux_s;
  logic [DIV_WIDTH-1:0] bit_len_s;
  logic                 fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0]           fifo_dout_s;
  logic [AW:0]          fifo_count_s;
  logic                 unused_bits_s;

  assign unused_bits_s = ^{bus.bus_addr, bus.bus_data_w};

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (txdata_wr_s),
    .pop   (fifo_pop_s),
    .din   (bus.bus_data_w[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Bus decode and sticky-overflow set/clear conditions
  always_comb begin
    reg_off_s   = bus.bus_addr[1:0];
    wr_en_s     = bus.sel && (bus.bus_mask_w != 4'b0000);
    rd_en_s     = bus.sel && (bus.bus_mask_w == 4'b0000);
    txdata_wr_s = wr_en_s && (reg_off_s == REG_TXDATA) && bus.bus_mask_w[0];
    ovf_set_s   = txdata_wr_s && fifo_full_s && !fifo_pop_s;
    ovf_clr_s   = wr_en_s && (reg_off_s == REG_STATUS) && bus.bus_mask_w[0]
                  && bus.bus_data_w[ST_OVF];
    bit_len_s   = eff_div(div_r) - DIV_WIDTH'(1);
  end

  // Read-data multiplexer
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (reg_off_s)
      REG_STATUS: begin
        rd_mux_s[ST_FULL]                 = fifo_full_s;
        rd_mux_s[ST_EMPTY]                = fifo_empty_s;
        rd_mux_s[ST_BUSY]                 = (state_r != IDLE);
        rd_mux_s[ST_OVF]                  = ovf_r;
        rd_mux_s[ST_COUNT_LSB +: (AW+1)]  = fifo_count_s;
      end
      REG_DIVISOR: rd_mux_s[DIV_WIDTH-1:0] = div_r;
      default:     rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Control registers and registered read data
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_r   <= DIV_WIDTH'(DIV_RESET);
      ovf_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      if (wr_en_s && (reg_off_s == REG_DIVISOR)) begin
        for (int i = 0; i < DIV_WIDTH; i++) begin
          if (bus.bus_mask_w[i/8]) begin
            div_r[i] <= bus.bus_data_w[i];
          end
        end
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
      rdata_r <= rd_en_s ? rd_mux_s : 32'h0000_0000;
    end
  end

  // Serialiser next-state: every bit reloads cnt from the current divisor
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    bit_s      = bit_r;
    sh_s       = sh_r;
    tx_s       = tx_r;
    fifo_pop_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          sh_s       = fifo_dout_s;
          tx_s       = 1'b0;
          cnt_s      = bit_len_s;
          state_s    = START;
        end else begin
          tx_s = 1'b1;
        end
      end
      START: begin
        if (cnt_r == '0) begin
          tx_s    = sh_r[0];
          cnt_s   = bit_len_s;
          bit_s   = 3'd0;
          state_s = DATA;
        end else begin
          cnt_s = cnt_r - DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (cnt_r == '0) begin
          cnt_s = bit_len_s;
          if (bit_r == 3'd7) begin
            tx_s    = 1'b1;
            state_s = STOP;
          end else begin
            sh_s  = {1'b0, sh_r[7:1]};
            tx_s  = sh_r[1];
            bit_s = bit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r - DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (cnt_r == '0) begin
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            sh_s       = fifo_dout_s;
            tx_s       = 1'b0;
            cnt_s      = bit_len_s;
            state_s    = START;
          end else begin
            tx_s    = 1'b1;
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r - DIV_WIDTH'(1);
        end
      end
      default: begin
        tx_s    = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Serialiser state registers; reset aborts any frame with the line high
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      sh_r    <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      sh_r    <= sh_s;
      tx_r    <= tx_s;
    end
  end

  assign tx             = tx_r;
  assign irq            = fifo_empty_s && (state_r == IDLE);
  assign bus.bus_data_r = rdata_r;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed plus randomised bench for uart_tx_mmio; expected line levels come
// from the 8N1 framing rule (start 0, LSB-first data, stop 1, div cycles/bit).
module tb_uart_tx_mmio;
  import uart_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic tx;
  logic irq;
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic [7:0] exp_q[$];

  uart_tx_mmio_if bus_if();

  uart_tx_mmio #(.FIFO_DEPTH(8), .DIV_WIDTH(16), .DIV_RESET(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] data, input logic [3:0] mask);
    bus_if.sel        = 1'b1;
    bus_if.bus_addr   = {28'h0, off};
    bus_if.bus_data_w = data;
    bus_if.bus_mask_w = mask;
    tick();
    bus_if.sel        = 1'b0;
    bus_if.bus_data_w = 32'h0;
    bus_if.bus_mask_w = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] data);
    bus_if.sel        = 1'b1;
    bus_if.bus_addr   = {28'h0, off};
    bus_if.bus_mask_w = 4'h0;
    tick();
    data       = bus_if.bus_data_r;
    bus_if.sel = 1'b0;
  endtask

  // Bits before n_a last d_a cycles, later bits d_b; positions below k0 are skipped.
  task automatic check_frame(input string tag, input logic [7:0] b, input int d_a,
                             input int n_a, input int d_b, input int k0);
    int   pos;
    int   dur;
    logic exp_bit;
    pos = 0;
    for (int i = 0; i < 10; i++) begin
      dur     = (i < n_a) ? d_a : d_b;
      exp_bit = (i == 0) ? 1'b0 : ((i == 9) ? 1'b1 : b[i-1]);
      for (int c = 0; c < dur; c++) begin
        if (pos >= k0) begin
          check(tag, {31'h0, tx}, {31'h0, exp_bit});
          tick();
        end
        pos++;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          div_v;
    int          d;
    int          n;
    bit          seen_low;

    bus_if.sel        = 1'b0;
    bus_if.bus_addr   = 30'h0;
    bus_if.bus_data_w = 32'h0;
    bus_if.bus_mask_w = 4'h0;
    reset = 1'b0;
    tick();
    tick();
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_irq", {31'h0, irq}, 32'h1);
    check("reset_rdata", bus_if.bus_data_r, 32'h0);
    reset = 1'b1;
    tick();

    bus_read(REG_STATUS, rd);
    check("status_after_reset", rd, 32'h0000_0002);
    bus_read(REG_DIVISOR, rd);
    check("divisor_after_reset", rd, 32'h0000_0010);
    bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
    check("rdata_after_write", bus_if.bus_data_r, 32'h0);
    bus_read(2'd3, rd);
    check("reserved_read", rd, 32'h0);
    bus_read(REG_TXDATA, rd);
    check("txdata_read", rd, 32'h0);

    // Single frame 0x55 at four cycles per bit
    bus_write(REG_DIVISOR, 32'd4, 4'b0011);
    bus_write(REG_TXDATA, 32'h0000_0055, 4'b0001);
    check("tx_idle_at_write_edge", {31'h0, tx}, 32'h1);
    tick();
    check("start_latency", {31'h0, tx}, 32'h0);
    check("irq_low_in_frame", {31'h0, irq}, 32'h0);
    check_frame("frame_55", 8'h55, 4, 10, 4, 0);
    check("irq_after_frame_55", {31'h0, irq}, 32'h1);
    check("tx_after_frame_55", {31'h0, tx}, 32'h1);

    // Back-to-back frames with no idle gap
    bus_write(REG_TXDATA, 32'h0000_00A5, 4'b0001);
    bus_write(REG_TXDATA, 32'h0000_003C, 4'b0001);
    check("b2b_start", {31'h0, tx}, 32'h0);
    bus_read(REG_STATUS, rd);
    check("b2b_status_count1", rd, 32'h0000_0104);
    check_frame("frame_a5", 8'hA5, 4, 10, 4, 1);
    check_frame("frame_3c", 8'h3C, 4, 10, 4, 0);
    check("irq_after_b2b", {31'h0, irq}, 32'h1);

    // Random divisors and bursts, checked against a byte queue
    for (int r = 0; r < 4; r++) begin
      div_v = int'($urandom_range(0, 5));
      d     = (div_v == 0) ? 1 : div_v;
      bus_write(REG_DIVISOR, 32'(div_v), 4'b0011);
      n = int'($urandom_range(2, 6));
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(REG_TXDATA, {8'($urandom), 8'($urandom), 8'($urandom), b}, 4'b0001);
      end
      check_frame("rand_frame", exp_q.pop_front(), d, 10, d, n - 2);
      while (exp_q.size() > 0) begin
        check_frame("rand_frame", exp_q.pop_front(), d, 10, d, 0);
      end
      check("rand_irq_idle", {31'h0, irq}, 32'h1);
    end

    // Divisor zero gives one-cycle bits
    bus_write(REG_DIVISOR, 32'd0, 4'b0011);
    bus_read(REG_DIVISOR, rd);
    check("divisor_zero_read", rd, 32'h0);
    b = 8'($urandom);
    bus_write(REG_TXDATA, {24'h0, b}, 4'b0001);
    tick();
    check_frame("frame_div0", b, 1, 10, 1, 0);
    check("irq_after_div0", {31'h0, irq}, 32'h1);

    // Divisor change during bit 1 applies from bit 2 onwards
    bus_write(REG_DIVISOR, 32'd4, 4'b0011);
    b = 8'($urandom);
    bus_write(REG_TXDATA, {24'h0, b}, 4'b0001);
    tick();
    check("midframe_start", {31'h0, tx}, 32'h0);
    repeat (5) tick();
    bus_write(REG_DIVISOR, 32'd2, 4'b0011);
    check_frame("frame_div_change", b, 4, 2, 2, 6);
    check("irq_after_div_change", {31'h0, irq}, 32'h1);

    // Overflow with a long frame holding the transmitter
    bus_write(REG_DIVISOR, 32'd100, 4'b0011);
    for (int j = 0; j < 10; j++) begin
      bus_write(REG_TXDATA, 32'($urandom), 4'b0001);
    end
    check("rdata_zero_before_read", bus_if.bus_data_r, 32'h0);
    bus_read(REG_STATUS, rd);
    check("status_full_overflow", rd, 32'h0000_080D);
    tick();
    check("rdata_zero_sel0", bus_if.bus_data_r, 32'h0);
    bus_write(REG_STATUS, 32'h0000_0008, 4'b0001);
    bus_read(REG_STATUS, rd);
    check("status_overflow_cleared", rd, 32'h0000_0805);
    check("long_frame_start", {31'h0, tx}, 32'h0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus_read(REG_STATUS, rd);
    check("status_after_flush", rd, 32'h0000_0002);

    // Reset during data bit 3 aborts the frame and discards the queue
    bus_write(REG_DIVISOR, 32'd4, 4'b0011);
    bus_write(REG_TXDATA, 32'h0000_0000, 4'b0001);
    bus_write(REG_TXDATA, 32'h0000_0000, 4'b0001);
    repeat (17) tick();
    check("data_bit3_low", {31'h0, tx}, 32'h0);
    reset = 1'b0;
    tick();
    check("abort_tx", {31'h0, tx}, 32'h1);
    check("abort_irq", {31'h0, irq}, 32'h1);
    check("abort_rdata", bus_if.bus_data_r, 32'h0);
    reset = 1'b1;
    bus_read(REG_STATUS, rd);
    check("abort_status", rd, 32'h0000_0002);
    bus_read(REG_DIVISOR, rd);
    check("abort_divisor", rd, 32'h0000_0010);
    seen_low = 1'b0;
    for (int j = 0; j < 200; j++) begin
      tick();
      if (tx == 1'b0) begin
        seen_low = 1'b1;
      end
    end
    check("no_start_after_abort", {31'h0, seen_low}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU word bus, a sibling slave to the block RAM; addressed via an external decode strobe.
- Uses the same bus signalling as the RAM:
  - 30-bit word address.
  - 32-bit read/write data.
  - 4-bit byte write mask; mask zero means read.
  - Registered read data, 1-cycle latency.
- Buffers bytes in a small FIFO and serialises them 8N1 on `tx`.
- Provides test/console output for simulation and FPGA.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- DIV_WIDTH, 16, width of the baud divisor register.
- DIV_RESET, 16, divisor after reset, in clock cycles per bit.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- sel  in  1  address decode hit for this peripheral.
- bus_addr  in  30  word address; only [1:0] is used as the register offset.
- bus_data_r  out  32  registered read data.
- bus_data_w  in  32  write data.
- bus_mask_w  in  4  byte write enables; all-zero means read.
- tx  out  1  serial line; idles high.
- irq  out  1  high while the FIFO is empty and the transmitter is idle.

Behaviour:
- Register map (offset = bus_addr[1:0]):
  - 0 TXDATA: write enqueues byte [7:0] if mask[0] is set; reads 0.
  - 1 STATUS, read-only except bit 3:
    - bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky).
    - [15:8] FIFO count.
    - Writing with mask[0] set and data bit3=1 clears overflow.
  - 2 DIVISOR: [DIV_WIDTH-1:0], writable by byte lane; zero-extended on read.
  - 3: reserved; reads 0, writes ignored.
- Write access: sel=1 and mask!=0, applied at the clock edge.
- Read access: sel=1 and mask==0. bus_data_r <= register at the edge, valid the cycle after. On any write, or when sel=0, bus_data_r <= 0.
- Reset (reset=0 at an edge):
  - tx=1, irq=1, bus_data_r=0.
  - FIFO emptied, state IDLE, divisor=DIV_RESET, overflow=0.
  - Overrides everything, including a frame in progress; tx returns high at that edge.
- FIFO push:
  - A TXDATA write while full is dropped and sets overflow.
  - A push while full in the same cycle as a pop is accepted; count is unchanged.
- Transmit FSM, with baud counter `cnt` and bit index `bit`:
  - IDLE: if FIFO is non-empty, pop into the shift register, tx<=0, cnt<=div-1, go to START.
  - START: when cnt==0, tx<=sh[0], cnt<=div-1, bit<=0, go to DATA; else decrement cnt.
  - DATA: when cnt==0, if bit==7 then tx<=1, cnt<=div-1, go to STOP; else shift right, tx<=next bit, bit++. Otherwise decrement cnt.
  - STOP: when cnt==0, if FIFO is non-empty, pop and enter START directly with tx<=0 (back-to-back, no idle gap); else go to IDLE. Otherwise decrement cnt.
- Timing:
  - Effective divisor is max(DIVISOR,1), latched when each bit starts; a DIVISOR write mid-frame affects the following bits only.
  - Each bit lasts exactly div cycles; a frame lasts 10*div cycles.
  - TXDATA written at edge N with the transmitter idle: tx falls at edge N+1.
  - Data is sent LSB first.
- busy = state != IDLE.
- irq = empty & !busy, registered-equivalent (driven from state registers only).
- Counter widths: cnt is DIV_WIDTH bits, bit is 3 bits, FIFO pointers are log2(FIFO_DEPTH) bits and wrap; count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package uart_pkg:
  - Register offset constants (REG_TXDATA=0, REG_STATUS=1, REG_DIVISOR=2).
  - STATUS bit position constants.
  - Enum type for tx_state_t {IDLE, START, DATA, STOP}.
- Sub-module uart_fifo:
  - Synchronous FIFO, 8-bit wide, depth parameter.
  - Ports: push/pop/din/dout/full/empty/count.
  - Same clock and active-low sync reset.
  - Read is first-word-fall-through.

Test Plan:
- Reset, then DIV=4, write TXDATA 0x55 → tx low at next edge. Then each bit lasts 4 cycles: tx sequence 0,1,0,1,0,1,0,1,0,1 (start, then LSB first, then stop). irq drops during the frame and rises 40 cycles after start.
- Write 0xA5, 0x3C back-to-back → second start bit immediately follows the first stop bit, no idle gap. STATUS count reads 1 after the first pop.
- With tx held in a long frame (DIV=100), write 9 bytes with depth 8 → 8 queued, 1 popped at once, the 9th is accepted. A 10th write sets overflow; STATUS reads full=1, overflow=1. Writing STATUS with 0x8 clears overflow.
- Read STATUS with sel=1, mask=0 → value appears on bus_data_r exactly one cycle later. With sel=0, bus_data_r is 0.
- Write DIVISOR=0 → bits last 1 cycle, so a frame lasts 10 cycles. Write DIVISOR=2 mid-frame → subsequent bits last 2 cycles.
- Assert reset for one cycle during DATA bit 3 → tx=1, irq=1, count=0, DIVISOR=16 after that edge. No further start bit appears.
